// File: rtl/key_event_pkg.sv
// Shared types and helpers for the keypad event front-end.
// The KEY_EVENT_REPEAT_EN build option is handled in key_event_fsm.sv.
package key_event_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        REPEAT,
        REL_DEB
    } key_fsm_e;

    // Raw and debounced key levels are active-low, so "released" reads as 1
    localparam logic KEY_RELEASED = 1'b1;

    // Counter width: room for the largest terminal tick count, plus one bit
    function automatic int cnt_width(input int deb_ticks, input int long_ticks, input int rep_ticks);
        int largest;
        largest = deb_ticks;
        if (long_ticks > largest) largest = long_ticks;
        if (rep_ticks > largest) largest = rep_ticks;
        return $clog2(largest) + 1;
    endfunction

endpackage

// File: rtl/key_event_fsm.sv
// One key channel: 2-flop synchroniser, tick-based debounce FSM, and
// registered level/pulse outputs.
// Build option KEY_EVENT_REPEAT_EN adds the long-press auto-repeat
// (REPEAT state); without it HELD simply waits for release and
// repeat_pulse is tied low.
module key_event_fsm
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 500,
    parameter int REPEAT_TICKS   = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_n,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_TICKS, LONG_TICKS, REPEAT_TICKS);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS);
`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS);
`endif

    logic             sync1;
    logic             sync2;
    logic             s;
    key_fsm_e         state;
    key_fsm_e         state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             key_state_nxt;
    logic             press_nxt;
    logic             release_nxt;
`ifdef KEY_EVENT_REPEAT_EN
    logic             repeat_nxt;
`endif

    assign s = sync2;

    // Two-flop synchroniser for the asynchronous raw key input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= KEY_RELEASED;
            sync2 <= KEY_RELEASED;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Next-state logic; a change of s wins over tick counting, and the
    // counter is cleared on reaching its terminal value so it never wraps
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        key_state_nxt = key_state;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
        repeat_nxt    = 1'b0;
`endif
        cnt_inc       = cnt + CNT_W'(1);
        case (state)
            IDLE: begin
                if (!s) begin
                    state_nxt = PRESS_DEB;
                    cnt_nxt   = '0;
                end
            end
            PRESS_DEB: begin
                if (s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    if (cnt_inc == DEB_LAST) begin
                        state_nxt     = HELD;
                        cnt_nxt       = '0;
                        press_nxt     = 1'b1;
                        key_state_nxt = ~KEY_RELEASED;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            HELD: begin
                if (s) begin
                    state_nxt = REL_DEB;
                    cnt_nxt   = '0;
                end
`ifdef KEY_EVENT_REPEAT_EN
                else if (tick) begin
                    if (cnt_inc == LONG_LAST) begin
                        state_nxt  = REPEAT;
                        cnt_nxt    = '0;
                        repeat_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
`endif
            end
`ifdef KEY_EVENT_REPEAT_EN
            REPEAT: begin
                if (s) begin
                    state_nxt = REL_DEB;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    if (cnt_inc == REP_LAST) begin
                        cnt_nxt    = '0;
                        repeat_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
`endif
            REL_DEB: begin
                if (!s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    if (cnt_inc == DEB_LAST) begin
                        state_nxt     = IDLE;
                        cnt_nxt       = '0;
                        release_nxt   = 1'b1;
                        key_state_nxt = KEY_RELEASED;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            key_state     <= KEY_RELEASED;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            key_state     <= key_state_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

`ifdef KEY_EVENT_REPEAT_EN
    // Registered repeat pulse, one cycle per auto-repeat emission
    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= repeat_nxt;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_event_gen.sv
// Keypad front-end top: shared tick prescaler plus one key_event_fsm per key.
// Build option KEY_EVENT_REPEAT_EN enables long-press auto-repeat in every channel.
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int F_CLK          = 50000000,
    parameter int F_TICK         = 1000,
    parameter int N_KEYS         = 6,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 500,
    parameter int REPEAT_TICKS   = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] repeat_pulse,
    output logic              tick
);

    localparam int DIV   = F_CLK / F_TICK;
    localparam int PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_cnt;

    // tick marks the single cycle in which the prescaler sits at its last value
    assign tick = (pre_cnt == PRE_LAST);

    // Free-running prescaler counting 0..DIV-1
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_event_fsm #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS),
            .REPEAT_TICKS   (REPEAT_TICKS)
        ) u_key (
            .clk           (clk),
            .rst           (rst),
            .tick          (tick),
            .key_n         (key_n[k]),
            .key_state     (key_state[k]),
            .press_pulse   (press_pulse[k]),
            .release_pulse (release_pulse[k]),
            .repeat_pulse  (repeat_pulse[k])
        );
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen: directed scenarios plus random key
// activity, compared every cycle against a behavioural model of the key rules.
// Honours KEY_EVENT_REPEAT_EN when it is defined for the whole build.
module tb_key_event_gen;

    localparam int F_CLK  = 10;
    localparam int F_TICK = 1;
    localparam int DIV    = F_CLK / F_TICK;
    localparam int NK     = 2;
    localparam int DEB    = 3;
    localparam int LONG   = 5;
    localparam int REP    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] key_state;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] repeat_pulse;
    logic          tick;

    key_event_gen #(
        .F_CLK          (F_CLK),
        .F_TICK         (F_TICK),
        .N_KEYS         (NK),
        .DEBOUNCE_TICKS (DEB),
        .LONG_TICKS     (LONG),
        .REPEAT_TICKS   (REP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_n         (key_n),
        .key_state     (key_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse),
        .tick          (tick)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: each key has a debounced level; a disagreeing input
    // must persist for DEB ticks to flip it; held time is counted in ticks
    int            pc;
    logic [NK-1:0] syncA;
    logic [NK-1:0] syncB;
    bit            pressed   [NK];
    bit            disagree  [NK];
    int            runTicks  [NK];
    int            holdTicks [NK];
    logic [NK-1:0] expKeyState;
    logic [NK-1:0] expPress;
    logic [NK-1:0] expRelease;
    logic [NK-1:0] expRepeat;
    logic          expTick;

    // Event tallies for scenario-level checks
    int pressCnt   [NK];
    int releaseCnt [NK];
    int repeatCnt  [NK];
    int bothPressCnt;

    function automatic bit repeatDue(input int h);
`ifdef KEY_EVENT_REPEAT_EN
        return (h >= LONG) && (((h - LONG) % REP) == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input logic r, input logic [NK-1:0] k);
        bit tickNow;
        bit sNow;
        if (r) begin
            pc    = 0;
            syncA = '1;
            syncB = '1;
            for (int i = 0; i < NK; i++) begin
                pressed[i]   = 1'b0;
                disagree[i]  = 1'b0;
                runTicks[i]  = 0;
                holdTicks[i] = 0;
            end
            expKeyState = '1;
            expPress    = '0;
            expRelease  = '0;
            expRepeat   = '0;
            expTick     = 1'b0;
        end else begin
            tickNow    = (pc == DIV - 1);
            pc         = tickNow ? 0 : pc + 1;
            expTick    = (pc == DIV - 1);
            expPress   = '0;
            expRelease = '0;
            expRepeat  = '0;
            for (int i = 0; i < NK; i++) begin
                sNow = syncB[i];
                if (sNow == !pressed[i]) begin
                    if (disagree[i]) begin
                        disagree[i]  = 1'b0;
                        holdTicks[i] = 0;
                    end else if (pressed[i] && tickNow) begin
                        holdTicks[i]++;
                        if (repeatDue(holdTicks[i])) expRepeat[i] = 1'b1;
                    end
                end else begin
                    if (!disagree[i]) begin
                        disagree[i] = 1'b1;
                        runTicks[i] = 0;
                    end else if (tickNow) begin
                        runTicks[i]++;
                        if (runTicks[i] == DEB) begin
                            pressed[i]   = !pressed[i];
                            disagree[i]  = 1'b0;
                            holdTicks[i] = 0;
                            if (pressed[i]) expPress[i] = 1'b1;
                            else            expRelease[i] = 1'b1;
                        end
                    end
                end
                expKeyState[i] = !pressed[i];
            end
            syncB = syncA;
            syncA = k;
        end
    endtask

    // One clock cycle: drive on the falling edge, model and check after the rising edge
    task automatic applyStimulus(input logic r, input logic [NK-1:0] k);
        @(negedge clk);
        rst   = r;
        key_n = k;
        @(posedge clk);
        modelStep(r, k);
        #1;
        checkOutput("key_state",     int'(key_state),     int'(expKeyState));
        checkOutput("press_pulse",   int'(press_pulse),   int'(expPress));
        checkOutput("release_pulse", int'(release_pulse), int'(expRelease));
        checkOutput("repeat_pulse",  int'(repeat_pulse),  int'(expRepeat));
        checkOutput("tick",          int'(tick),          int'(expTick));
        for (int i = 0; i < NK; i++) begin
            if (press_pulse[i])   pressCnt[i]++;
            if (release_pulse[i]) releaseCnt[i]++;
            if (repeat_pulse[i])  repeatCnt[i]++;
        end
        if (press_pulse == '1) bothPressCnt++;
    endtask

    task automatic runCycles(input int n, input logic [NK-1:0] k);
        for (int c = 0; c < n; c++) applyStimulus(1'b0, k);
    endtask

    task automatic clearTallies();
        for (int i = 0; i < NK; i++) begin
            pressCnt[i]   = 0;
            releaseCnt[i] = 0;
            repeatCnt[i]  = 0;
        end
        bothPressCnt = 0;
    endtask

    task automatic measureTickPeriod();
        int first;
        int second;
        first  = -1;
        second = -1;
        for (int c = 0; c < 40 && second < 0; c++) begin
            applyStimulus(1'b0, 2'b11);
            if (tick) begin
                if (first < 0) first = c;
                else           second = c;
            end
        end
        if (second < 0) checkOutput("tick_timeout", 0, 1);
        else            checkOutput("tick_period", second - first, DIV);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    int expRepeats;
    int expOneRepeat;
    logic [NK-1:0] randVal;
    int remain [NK];

    initial begin
        clearTallies();

        // Reset with keys pressed: outputs must stay at reset values
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 2'b00);
        checkOutput("reset_key_state", int'(key_state), 3);
        applyStimulus(1'b0, 2'b11);
        checkOutput("post_reset_pulses", int'({press_pulse, release_pulse, repeat_pulse}), 0);
        measureTickPeriod();

        // Clean press and release on key 0
        clearTallies();
        runCycles(60, 2'b10);
        checkOutput("clean_press_cnt", pressCnt[0], 1);
        checkOutput("clean_held_level", int'(key_state[0]), 0);
        runCycles(60, 2'b11);
        checkOutput("clean_release_cnt", releaseCnt[0], 1);
        checkOutput("clean_released_level", int'(key_state[0]), 1);

        // Bouncing input never lasts long enough to be accepted
        clearTallies();
        for (int c = 0; c < 60; c++) applyStimulus(1'b0, {1'b1, (((c / 7) % 2) == 0) ? 1'b0 : 1'b1});
        runCycles(40, 2'b11);
        checkOutput("bounce_press_cnt", pressCnt[0], 0);
        checkOutput("bounce_level", int'(key_state[0]), 1);

        // Long hold: press, then repeats at +5, +7, +9, +11 ticks
`ifdef KEY_EVENT_REPEAT_EN
        expRepeats   = 4;
        expOneRepeat = 1;
`else
        expRepeats   = 0;
        expOneRepeat = 0;
`endif
        clearTallies();
        runCycles(148, 2'b10);
        runCycles(60, 2'b11);
        checkOutput("long_press_cnt", pressCnt[0], 1);
        checkOutput("long_repeat_cnt", repeatCnt[0], expRepeats);
        checkOutput("long_release_cnt", releaseCnt[0], 1);

        // Release bounce while held restarts the long-press timer
        clearTallies();
        runCycles(45, 2'b10);
        runCycles(10, 2'b11);
        runCycles(40, 2'b10);
        checkOutput("relbounce_early_repeat", repeatCnt[0], 0);
        runCycles(13, 2'b10);
        checkOutput("relbounce_first_repeat", repeatCnt[0], expOneRepeat);
        checkOutput("relbounce_press_cnt", pressCnt[0], 1);
        checkOutput("relbounce_no_release", releaseCnt[0], 0);
        runCycles(60, 2'b11);
        checkOutput("relbounce_release_cnt", releaseCnt[0], 1);

        // Both keys together, then reset while they are in auto-repeat
        clearTallies();
        runCycles(100, 2'b00);
        checkOutput("both_press_same_cycle", bothPressCnt, 1);
        clearTallies();
        applyStimulus(1'b1, 2'b11);
        applyStimulus(1'b1, 2'b11);
        checkOutput("midreset_key_state", int'(key_state), 3);
        runCycles(60, 2'b11);
        checkOutput("midreset_no_release", releaseCnt[0] + releaseCnt[1], 0);

        // Random key activity with occasional resets
        for (int i = 0; i < NK; i++) remain[i] = 0;
        randVal = '1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NK; i++) begin
                if (remain[i] == 0) begin
                    randVal[i] = 1'($urandom_range(0, 1));
                    remain[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(80, 200))
                                                             : int'($urandom_range(1, 40));
                end
                remain[i]--;
            end
            applyStimulus(($urandom_range(0, 399) == 0), randVal);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
